// File: rtl/banked_memory.sv
// banked_memory: single-write / single-read storage array with per-byte
// write enables, a registered read with a valid strobe, write-first
// forwarding on same-address collisions, and a post-reset zeroing sweep.
//
// Handshake: requests have no ready/backpressure. A request is accepted on a
// rising edge when busy=0 and reset=0. An accepted read produces exactly one
// data_valid=1 cycle on the following edge, and data_out carries the result.
// While busy=1 every request is dropped.
module banked_memory #(
   parameter int MEMORY_DATA_WIDTH    = 256,
   parameter int MEMORY_ADDRESS_WIDTH = 2,
   parameter bit CLEAR_ON_RESET       = 1'b1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              write,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0]   addr_in,
   input  logic [MEMORY_DATA_WIDTH-1:0]      data_in,
   input  logic [MEMORY_DATA_WIDTH/8-1:0]    byte_en,
   input  logic                              read,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0]   addr_out,
   output logic [MEMORY_DATA_WIDTH-1:0]      data_out,
   output logic                              data_valid,
   output logic                              busy,
   output logic                              o_dbg_state
);

   localparam int DEPTH  = 1 << MEMORY_ADDRESS_WIDTH;
   localparam int NBYTES = MEMORY_DATA_WIDTH / 8;
   localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_IDX =
      MEMORY_ADDRESS_WIDTH'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                            r_state;
   state_t                            w_state_next;
   logic [MEMORY_ADDRESS_WIDTH-1:0]   r_clear_cnt;
   logic [MEMORY_DATA_WIDTH-1:0]      r_mem [DEPTH];
   logic [MEMORY_DATA_WIDTH-1:0]      r_data_out;
   logic                              r_data_valid;

   logic [MEMORY_DATA_WIDTH-1:0]      w_merged;
   logic                              w_ready;
   logic                              w_clear_we;
   logic                              w_wr_en;
   logic                              w_rd_en;
   logic                              w_collide;

   assign w_ready    = (r_state == ST_READY);
   assign w_clear_we = !reset && (r_state == ST_CLEAR);
   assign w_wr_en    = !reset && w_ready && write;
   assign w_rd_en    = !reset && w_ready && read;
   assign w_collide  = write && (addr_in == addr_out);

   // Byte-lane merge of incoming data over the currently stored word.
   always_comb begin
      w_merged = r_mem[addr_in];
      for (int i = 0; i < NBYTES; i++) begin
         if (byte_en[i]) begin
            w_merged[8*i +: 8] = data_in[8*i +: 8];
         end
      end
   end

   // State register and clear counter; reset restarts the sweep from entry 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         r_clear_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_CLEAR) begin
            r_clear_cnt <= r_clear_cnt + MEMORY_ADDRESS_WIDTH'(1);
         end
      end
   end

   // Next-state: leave CLEAR once the last entry has been zeroed.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_clear_cnt == LAST_IDX) w_state_next = ST_READY;
         ST_READY: w_state_next = ST_READY;
         default:  w_state_next = ST_READY;
      endcase
   end

   // Array update: sweep zeroing or merged user write (mutually exclusive).
   always_ff @(posedge clk) begin
      if (w_clear_we) begin
         r_mem[r_clear_cnt] <= '0;
      end else if (w_wr_en) begin
         r_mem[addr_in] <= w_merged;
      end
   end

   // Registered read; a same-address write forwards its merged word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= w_rd_en;
         if (w_rd_en) begin
            r_data_out <= w_collide ? w_merged : r_mem[addr_out];
         end
      end
   end

   assign data_out    = r_data_out;
   assign data_valid  = r_data_valid;
   assign busy        = (r_state == ST_CLEAR);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory (default parameters: 256b x 4).
module tb_banked_memory;

   logic         clk = 1'b0;
   logic         reset;
   logic         write;
   logic [1:0]   addr_in;
   logic [255:0] data_in;
   logic [31:0]  byte_en;
   logic         read;
   logic [1:0]   addr_out;
   logic [255:0] data_out;
   logic         data_valid;
   logic         busy;
   logic         dbg_state;

   // Clock
   always #5 clk = ~clk;

   banked_memory dut (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .addr_in    (addr_in),
      .data_in    (data_in),
      .byte_en    (byte_en),
      .read       (read),
      .addr_out   (addr_out),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .o_dbg_state(dbg_state)
   );

   // Reference model and scoreboard
   logic [255:0] model_mem [4];
   logic [255:0] exp_q [$];
   logic [255:0] last_out;
   int           clear_left;
   int           n_checks = 0;
   int           n_pass   = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset(input logic with_req);
      reset    = 1'b1;
      write    = with_req;
      read     = with_req;
      addr_in  = 2'd1;
      addr_out = 2'd1;
      data_in  = {32{8'h3C}};
      byte_en  = '1;
      @(posedge clk); #1;
      check("rst_data_out", data_out, '0);
      check("rst_valid", {255'b0, data_valid}, '0);
      check("rst_busy", {255'b0, busy}, 256'd1);
      reset = 1'b0;
      write = 1'b0;
      read  = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      clear_left = 4;
      last_out   = '0;
   endtask

   task automatic cycle(input logic wr, input logic [1:0] wa, input logic [255:0] wd,
                        input logic [31:0] be, input logic rd, input logic [1:0] ra);
      logic [255:0] merged;
      logic [255:0] e;
      logic         pushed;
      check("busy", {255'b0, busy}, {255'b0, (clear_left > 0)});
      check("state", {255'b0, dbg_state}, {255'b0, (clear_left == 0)});
      write    = wr;
      addr_in  = wa;
      data_in  = wd;
      byte_en  = be;
      read     = rd;
      addr_out = ra;
      pushed   = 1'b0;
      if (clear_left == 0) begin
         merged = model_mem[wa];
         for (int i = 0; i < 32; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
         if (rd) begin
            exp_q.push_back((wr && wa == ra) ? merged : model_mem[ra]);
            pushed = 1'b1;
         end
         if (wr) model_mem[wa] = merged;
      end else begin
         clear_left--;
      end
      @(posedge clk); #1;
      write = 1'b0;
      read  = 1'b0;
      check("valid", {255'b0, data_valid}, {255'b0, pushed});
      if (pushed) begin
         e = exp_q.pop_front();
         last_out = e;
         check("rdata", data_out, e);
      end else begin
         check("hold", data_out, last_out);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 2'd0, '0, '0, 1'b0, 2'd0);
   endtask

   logic [255:0] rnd;

   initial begin
      reset = 1'b1; write = 1'b0; read = 1'b0;
      addr_in = '0; addr_out = '0; data_in = '0; byte_en = '0;

      // Clear sweep, then read every entry back as zero (back-to-back).
      do_reset(1'b0);
      idle(4);
      for (int a = 0; a < 4; a++) cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'(a));

      // Full write then read; untouched entry stays zero.
      cycle(1'b1, 2'd1, 256'h1, '1, 1'b0, 2'd0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd1);
      check("full_wr", last_out, 256'h1);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd2);

      // Partial write over all-0xFF entry: lanes 0 and 31 cleared.
      cycle(1'b1, 2'd2, {32{8'hFF}}, '1, 1'b0, 2'd0);
      cycle(1'b1, 2'd2, '0, 32'h8000_0001, 1'b0, 2'd0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd2);
      check("partial", data_out, {8'h00, {30{8'hFF}}, 8'h00});

      // Collision: write-first forwarding.
      cycle(1'b1, 2'd3, {32{8'hA5}}, '1, 1'b1, 2'd3);
      check("collide", data_out, {32{8'hA5}});
      // Partial collision merges with old contents; different addresses independent.
      cycle(1'b1, 2'd3, {32{8'h11}}, 32'h0000_00F0, 1'b1, 2'd3);
      cycle(1'b1, 2'd0, {32{8'h77}}, '1, 1'b1, 2'd1);
      // byte_en=0 is a no-op.
      cycle(1'b1, 2'd1, {32{8'hEE}}, '0, 1'b1, 2'd1);

      // Random traffic.
      for (int n = 0; n < 40; n++) begin
         rnd = {8{$urandom()}};
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd,
               $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end

      // Requests during the sweep are ignored.
      do_reset(1'b0);
      idle(1);
      cycle(1'b1, 2'd0, 256'h4, '1, 1'b1, 2'd0);
      idle(2);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd0);
      check("clear_ignored", data_out, '0);

      // Reset during sweep cycle 3 restarts a full 4-cycle sweep.
      cycle(1'b1, 2'd2, {32{8'h5A}}, '1, 1'b0, 2'd0);
      do_reset(1'b0);
      idle(2);
      do_reset(1'b0);
      idle(4);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd2);

      // Reset after a read, and reset together with requests.
      cycle(1'b1, 2'd1, {32{8'hC3}}, '1, 1'b0, 2'd0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd1);
      do_reset(1'b0);
      idle(4);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd1);
      cycle(1'b1, 2'd1, {32{8'h99}}, '1, 1'b1, 2'd1);
      do_reset(1'b1);
      idle(4);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 2'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
